// File: rtl/fft_bitrev_reorder.sv
`timescale 1ns/1ps
// fft_bitrev_reorder
// Output-reorder stage for the radix-2 SDC FFT core. Frames arrive in
// bit-reversed bin order and are buffered in a two-bank ping-pong memory.
// Each frame is re-emitted in natural order 0..N-1 as N contiguous samples.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input sample strobe (core's done)
//   in_re/im   input bin value, bit-reversed order
//   out_valid  output strobe; qualifies the four outputs below
//   out_re/im  value of bin out_index (0 when out_valid is low)
//   out_index  natural-order bin number
//   out_last   high with bin N-1 of each frame
module fft_bitrev_reorder #(
  parameter int LOG2N = 4,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_re,
  input  logic [W-1:0]     in_im,
  output logic             out_valid,
  output logic [W-1:0]     out_re,
  output logic [W-1:0]     out_im,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t state_q, state_d;

  logic [2*W-1:0]   mem [2][N];
  logic [LOG2N-1:0] wr_cnt, rd_cnt, rd_addr;
  logic             wr_sel, rd_sel;
  logic [1:0]       full, set_vec, clr_vec;
  logic             wr_en, wr_wrap, emit, rd_wrap;
  logic [2*W-1:0]   rd_word;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  always_comb begin
    wr_en   = in_valid & ~full[wr_sel];
    wr_wrap = wr_en & (wr_cnt == LAST);
    // Bin 0 is emitted on the same edge that leaves IDLE, so a full read
    // bank starts output without waiting a cycle in READ.
    emit    = (state_q == READ) | full[rd_sel];
    rd_wrap = emit & (rd_cnt == LAST);
    rd_addr = bitrev(rd_cnt);
    rd_word = mem[rd_sel][rd_addr];

    set_vec = '0;
    clr_vec = '0;
    if (wr_wrap) set_vec[wr_sel] = 1'b1;
    if (rd_wrap) clr_vec[rd_sel] = 1'b1;

    state_d = state_q;
    case (state_q)
      IDLE: if (full[rd_sel]) state_d = READ;
      READ: if (rd_wrap) state_d = full[~rd_sel] ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_sel][wr_cnt] <= {in_re, in_im};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      full      <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en)   wr_cnt <= wr_cnt + 1'b1;
      if (wr_wrap) wr_sel <= ~wr_sel;
      if (emit)    rd_cnt <= rd_cnt + 1'b1;
      if (rd_wrap) rd_sel <= ~rd_sel;
      // Set has priority over clear on the same flag.
      full <= (full & ~clr_vec) | set_vec;

      out_valid <= emit;
      if (emit) begin
        out_re    <= rd_word[2*W-1:W];
        out_im    <= rd_word[W-1:0];
        out_index <= rd_cnt;
        out_last  <= (rd_cnt == LAST);
      end else begin
        out_re    <= '0;
        out_im    <= '0;
        out_index <= '0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;

  localparam int LOG2N = 4;
  localparam int W     = 16;
  localparam int N     = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_re = '0, in_im = '0;
  logic          out_valid;
  logic [W-1:0]  out_re, out_im;
  logic [LOG2N-1:0] out_index;
  logic          out_last;

  fft_bitrev_reorder #(.LOG2N(LOG2N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, ovf_cnt = 0, zero_viol = 0;
  int perm[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  logic [15:0] ext[3] = '{16'h7FFF, 16'h8000, 16'hFFFF};
  logic [15:0] s_re[64], s_im[64];

  typedef struct {
    logic [15:0] in_re, in_im, exp_re, exp_im;
    logic [3:0]  exp_idx;
    logic        exp_last;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && in_valid && dut.full[dut.wr_sel]) begin
      ovf_cnt++;
      $display("FAIL overflow write into full bank t=%0t", $time);
    end
    if (!out_valid && (out_re != 0 || out_im != 0 || out_index != 0 || out_last))
      zero_viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic drive(input int start, input int cnt, input bit gapped,
                       input bit quiet, output int noisy);
    noisy = 0;
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      if (quiet && out_valid) noisy++;
      in_valid = 1'b1; in_re = s_re[start+i]; in_im = s_im[start+i];
      if (gapped) begin
        @(negedge clk);
        if (quiet && out_valid) noisy++;
        in_valid = 1'b0;
      end
    end
    if (!gapped) begin
      @(negedge clk);
      if (quiet && out_valid) noisy++;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_frames(input string tag, input int start, input int nf);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, 32'(out_valid), 32'd1);
    if (out_valid) begin
      for (int j = 0; j < nf * 16; j++) begin
        int f, k;
        if (j > 0) @(negedge clk);
        f = j / 16; k = j % 16;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_idx"}, 32'(out_index), 32'(k));
        chk({tag, "_last"}, 32'(out_last), 32'(k == 15));
        chk({tag, "_re"}, 32'(out_re), 32'(s_re[start + 16*f + perm[k]]));
        chk({tag, "_im"}, 32'(out_im), 32'(s_im[start + 16*f + perm[k]]));
      end
    end
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk(name, 32'(n), 32'd0);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_re"}, 32'(out_re), 32'd0);
    chk({name, "_im"}, 32'(out_im), 32'd0);
    chk({name, "_idx"}, 32'(out_index), 32'd0);
    chk({name, "_last"}, 32'(out_last), 32'd0);
  endtask

  initial begin
    int noisy;

    for (int i = 0; i < 16; i++) begin
      tbl[i].in_re    = 16'(i);
      tbl[i].in_im    = 16'(100 + i);
      tbl[i].exp_re   = 16'(perm[i]);
      tbl[i].exp_im   = 16'(100 + perm[i]);
      tbl[i].exp_idx  = 4'(i);
      tbl[i].exp_last = (i == 15);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Test 1: single frame, exact latency
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_re = tbl[i].in_re; in_im = tbl[i].in_im;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_not_early", 32'(out_valid), 32'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_idx", 32'(out_index), 32'(tbl[k].exp_idx));
      chk("t1_re", 32'(out_re), 32'(tbl[k].exp_re));
      chk("t1_im", 32'(out_im), 32'(tbl[k].exp_im));
      chk("t1_last", 32'(out_last), 32'(tbl[k].exp_last));
    end
    @(negedge clk);
    check_zero("t1_after");
    expect_quiet("t1_quiet", 5);

    // Test 2: three back-to-back frames
    for (int j = 0; j < 48; j++) begin
      s_re[j] = 16'(j * 257 + 3);
      s_im[j] = 16'(16'hA000 ^ (j * 131));
    end
    fork
      drive(0, 48, 1'b0, 1'b0, noisy);
      check_frames("t2", 0, 3);
    join
    @(negedge clk);
    check_zero("t2_after");
    expect_quiet("t2_quiet", 5);

    // Test 3: gapped input, same permutation as test 1
    for (int j = 0; j < 16; j++) begin
      s_re[j] = tbl[j].in_re; s_im[j] = tbl[j].in_im;
    end
    drive(0, 16, 1'b1, 1'b1, noisy);
    chk("t3_no_early", 32'(noisy), 32'd0);
    check_frames("t3", 0, 1);
    expect_quiet("t3_quiet", 5);

    // Test 4a: reset after 9 samples
    for (int j = 0; j < 16; j++) begin
      s_re[j] = 16'(16'h0B00 + j); s_im[j] = 16'(16'h0C00 + j);
      s_re[16+j] = 16'(16'h2200 + 3*j); s_im[16+j] = 16'(16'h3300 + 5*j);
    end
    drive(0, 9, 1'b0, 1'b1, noisy);
    #1 rst = 1'b1;
    #1 check_zero("t4a_rst");
    @(negedge clk);
    rst = 1'b0;
    drive(16, 16, 1'b0, 1'b1, noisy);
    chk("t4a_no_early", 32'(noisy), 32'd0);
    check_frames("t4a", 16, 1);
    expect_quiet("t4a_no_stale", 20);

    // Test 4b: reset during output cycle 5
    drive(0, 16, 1'b0, 1'b0, noisy);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (4) @(negedge clk);
    chk("t4b_cycle5", 32'(out_index), 32'd4);
    #1 rst = 1'b1;
    #1 check_zero("t4b_rst");
    @(negedge clk);
    rst = 1'b0;
    expect_quiet("t4b_no_stale", 20);
    drive(16, 16, 1'b0, 1'b1, noisy);
    check_frames("t4b", 16, 1);
    expect_quiet("t4b_quiet", 5);

    // Test 5: idle hold with a partial frame
    for (int j = 0; j < 16; j++) begin
      s_re[j] = 16'(16'h5A00 + 7*j); s_im[j] = 16'(16'hC300 - 9*j);
    end
    drive(0, 7, 1'b0, 1'b1, noisy);
    expect_quiet("t5_idle", 50);
    drive(7, 9, 1'b0, 1'b1, noisy);
    chk("t5_no_early", 32'(noisy), 32'd0);
    check_frames("t5", 0, 1);
    expect_quiet("t5_quiet", 5);

    // Test 6: extreme values
    for (int j = 0; j < 16; j++) begin
      s_re[j] = ext[j % 3]; s_im[j] = ext[(j + 1) % 3];
    end
    drive(0, 16, 1'b0, 1'b1, noisy);
    check_frames("t6", 0, 1);
    expect_quiet("t6_quiet", 5);

    chk("no_overflow", 32'(ovf_cnt), 32'd0);
    chk("zero_when_idle", 32'(zero_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
